// File: rtl/p3_execute.sv
// p3_execute: execute stage of the SIMPLE pipeline, with ALU/shifter, SZCV flags,
// the OUT port, a RUN/HALT machine and one stallable register toward the memory stage.
module p3_execute #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [WIDTH-1:0] alu1,
    input  logic [WIDTH-1:0] alu2,
    input  logic [3:0]       opcode,
    input  logic [3:0]       shamt,
    input  logic             writereg,
    input  logic [1:0]       memwrite,
    input  logic [2:0]       regaddress,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] storedata,
    input  logic [WIDTH-1:0] in_port,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             writereg_out,
    output logic [1:0]       memwrite_out,
    output logic [2:0]       regaddress_out,
    output logic [WIDTH-1:0] address_out,
    output logic [WIDTH-1:0] storedata_out,
    output logic [WIDTH-1:0] out_port,
    output logic             out_strobe,
    output logic             halted
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_nx;
    logic alu, accept, is_hlt, is_out, load;
    logic [WIDTH:0] sum, diff, sll_w, srl_w, sra_w;
    logic [WIDTH-1:0] rot, res;
    logic c, v, upd, wr;
    assign alu    = memwrite == 2'b00;
    assign accept = in_valid & ~stall & (state == RUN);
    assign is_hlt = alu & (opcode == 4'd15);
    assign is_out = alu & (opcode == 4'd13);
    assign load   = accept & ~is_hlt;
    assign halted = state == HALT;
    // The shifters carry one extra bit so the last bit shifted out lands in a fixed spot
    assign sum   = {1'b0, alu2} + {1'b0, alu1};
    assign diff  = {1'b0, alu2} - {1'b0, alu1};
    assign sll_w = {1'b0, alu2} << shamt;
    assign srl_w = {alu2, 1'b0} >> shamt;
    assign sra_w = $signed({alu2, 1'b0}) >>> shamt;
    assign rot   = WIDTH'({alu2, alu2} >> (WIDTH - int'(shamt)));
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        upd = 1'b0;
        wr  = writereg;
        if (!alu) res = address;
        else begin
            case (opcode)
                4'd0: begin
                    res = sum[WIDTH-1:0];
                    c   = sum[WIDTH];
                    v   = (alu2[WIDTH-1] == alu1[WIDTH-1]) & (sum[WIDTH-1] != alu2[WIDTH-1]);
                    upd = 1'b1;
                end
                4'd1, 4'd5: begin
                    res = diff[WIDTH-1:0];
                    c   = diff[WIDTH];
                    v   = (alu2[WIDTH-1] != alu1[WIDTH-1]) & (diff[WIDTH-1] != alu2[WIDTH-1]);
                    upd = 1'b1;
                    wr  = (opcode == 4'd5) ? 1'b0 : writereg;
                end
                4'd2: begin
                    res = alu2 & alu1;
                    upd = 1'b1;
                end
                4'd3: begin
                    res = alu2 | alu1;
                    upd = 1'b1;
                end
                4'd4: begin
                    res = alu2 ^ alu1;
                    upd = 1'b1;
                end
                4'd6: res = alu1;
                4'd8: begin
                    res = sll_w[WIDTH-1:0];
                    c   = sll_w[WIDTH];
                    upd = 1'b1;
                end
                4'd9: begin
                    res = rot;
                    c   = (shamt != 4'd0) & rot[0];
                    upd = 1'b1;
                end
                4'd10: begin
                    res = srl_w[WIDTH:1];
                    c   = srl_w[0];
                    upd = 1'b1;
                end
                4'd11: begin
                    res = sra_w[WIDTH:1];
                    c   = sra_w[0];
                    upd = 1'b1;
                end
                4'd12: res = in_port;
                4'd13: begin
                    res = alu1;
                    wr  = 1'b0;
                end
                default: wr = 1'b0;
            endcase
        end
    end
    always_comb begin
        state_nx = state;
        if (state == RUN && accept && is_hlt) state_nx = HALT;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RUN;
        else if (!stall) state <= state_nx;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            result         <= '0;
            flags          <= 4'b0000;
            writereg_out   <= 1'b0;
            memwrite_out   <= 2'b00;
            regaddress_out <= 3'd0;
            address_out    <= '0;
            storedata_out  <= '0;
            out_port       <= '0;
            out_strobe     <= 1'b0;
        end else if (!stall) begin
            out_valid  <= load;
            out_strobe <= accept & is_out;
            if (load) begin
                result         <= res;
                writereg_out   <= wr;
                memwrite_out   <= memwrite;
                regaddress_out <= regaddress;
                address_out    <= address;
                storedata_out  <= storedata;
            end
            if (accept & upd) flags <= {res[WIDTH-1], res == '0, c, v};
            if (accept & is_out) out_port <= alu1;
        end
    end
endmodule

// File: tb/tb_p3_execute.sv
// tb_p3_execute: directed and randomized checks of p3_execute against an arithmetic reference model.
module tb_p3_execute;
    logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, stall = 1'b0, writereg = 1'b0;
    logic [15:0] alu1 = '0, alu2 = '0, address = '0, storedata = '0, in_port = '0;
    logic [3:0] opcode = '0, shamt = '0;
    logic [1:0] memwrite = '0;
    logic [2:0] regaddress = '0;
    logic out_valid, writereg_out, out_strobe, halted;
    logic [15:0] result, address_out, storedata_out, out_port;
    logic [3:0] flags;
    logic [1:0] memwrite_out;
    logic [2:0] regaddress_out;
    int tests = 0, fails = 0;
    logic m_valid, m_wr, m_strobe, m_halted;
    logic [15:0] m_result, m_addr, m_sd, m_port;
    logic [3:0] m_flags;
    logic [1:0] m_mw;
    logic [2:0] m_ra;

    p3_execute #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall),
        .alu1(alu1), .alu2(alu2), .opcode(opcode), .shamt(shamt),
        .writereg(writereg), .memwrite(memwrite), .regaddress(regaddress),
        .address(address), .storedata(storedata), .in_port(in_port),
        .out_valid(out_valid), .result(result), .flags(flags),
        .writereg_out(writereg_out), .memwrite_out(memwrite_out),
        .regaddress_out(regaddress_out), .address_out(address_out),
        .storedata_out(storedata_out), .out_port(out_port),
        .out_strobe(out_strobe), .halted(halted)
    );

    always #5 clock = ~clock;

    function automatic int sx(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        {m_valid, m_wr, m_strobe, m_halted} = '0;
        {m_result, m_addr, m_sd, m_port} = '0;
        m_flags = '0;
        m_mw = '0;
        m_ra = '0;
    endtask

    // Applies the architectural effect of one clock edge given the inputs now being driven
    task automatic model_edge();
        int a, b, s, sh, d;
        logic [15:0] r;
        logic c, v, upd, wr;
        if (stall) return;
        m_valid = 1'b0;
        m_strobe = 1'b0;
        if (!in_valid || m_halted) return;
        if (memwrite != 2'b00) begin
            m_valid = 1'b1; m_result = address; m_wr = writereg; m_mw = memwrite;
            m_ra = regaddress; m_addr = address; m_sd = storedata;
            return;
        end
        if (opcode == 4'd15) begin
            m_halted = 1'b1;
            return;
        end
        a = int'(alu2); b = int'(alu1); sh = int'(shamt);
        c = 0; v = 0; upd = 0; wr = writereg; r = '0;
        case (opcode)
            4'd0: begin
                s = a + b; r = s[15:0]; c = s > 65535;
                d = sx(alu2) + sx(alu1); v = d > 32767 || d < -32768; upd = 1;
            end
            4'd1, 4'd5: begin
                s = a - b; r = s[15:0]; c = a < b;
                d = sx(alu2) - sx(alu1); v = d > 32767 || d < -32768; upd = 1;
                if (opcode == 4'd5) wr = 0;
            end
            4'd2: begin r = alu2 & alu1; upd = 1; end
            4'd3: begin r = alu2 | alu1; upd = 1; end
            4'd4: begin r = alu2 ^ alu1; upd = 1; end
            4'd6: r = alu1;
            4'd8: begin
                r = 16'(a << sh); c = sh > 0 && ((a >> (16 - sh)) & 1) == 1; upd = 1;
            end
            4'd9: begin
                r = alu2;
                for (int i = 0; i < sh; i++) begin
                    c = r[15];
                    r = {r[14:0], r[15]};
                end
                upd = 1;
            end
            4'd10: begin
                r = 16'(a >> sh); c = sh > 0 && ((a >> (sh - 1)) & 1) == 1; upd = 1;
            end
            4'd11: begin
                r = 16'(sx(alu2) >>> sh); c = sh > 0 && ((a >> (sh - 1)) & 1) == 1; upd = 1;
            end
            4'd12: r = in_port;
            4'd13: begin r = alu1; wr = 0; m_port = alu1; m_strobe = 1; end
            default: begin r = '0; wr = 0; end
        endcase
        m_valid = 1'b1; m_result = r; m_wr = wr; m_mw = 2'b00;
        m_ra = regaddress; m_addr = address; m_sd = storedata;
        if (upd) m_flags = {r[15], r == 16'd0, c, v};
    endtask

    task automatic check_all(input string t);
        chk({t, ".valid"}, out_valid, m_valid);
        chk({t, ".result"}, result, m_result);
        chk({t, ".flags"}, flags, m_flags);
        chk({t, ".wr"}, writereg_out, m_wr);
        chk({t, ".mw"}, memwrite_out, m_mw);
        chk({t, ".ra"}, regaddress_out, m_ra);
        chk({t, ".addr"}, address_out, m_addr);
        chk({t, ".sd"}, storedata_out, m_sd);
        chk({t, ".port"}, out_port, m_port);
        chk({t, ".strobe"}, out_strobe, m_strobe);
        chk({t, ".halted"}, halted, m_halted);
    endtask

    task automatic step(input string t);
        model_edge();
        @(posedge clock);
        #1;
        check_all(t);
    endtask

    task automatic set_op(input logic [3:0] op, input logic [15:0] a2, input logic [15:0] a1,
                          input logic [3:0] sh, input logic [1:0] mw, input logic [15:0] ad);
        in_valid = 1'b1; opcode = op; alu2 = a2; alu1 = a1; shamt = sh;
        memwrite = mw; address = ad; writereg = 1'b1;
        regaddress = 3'($urandom_range(0, 7)); storedata = 16'($urandom);
    endtask

    initial begin
        int k;
        model_reset();
        #2;
        check_all("reset");
        #10 reset = 1'b0;
        set_op(4'd0, 16'h7FFF, 16'h0001, 4'd0, 2'b00, 16'h1111);
        step("add");
        chk("add_res", result, 16'h8000);
        chk("add_flags", flags, 4'b1001);
        chk("add_valid", out_valid, 1'b1);
        set_op(4'd1, 16'h0003, 16'h0005, 4'd0, 2'b00, 16'h0);
        step("sub");
        chk("sub_res", result, 16'hFFFE);
        chk("sub_flags", flags, 4'b1010);
        set_op(4'd5, 16'h1234, 16'h1234, 4'd0, 2'b00, 16'h0);
        step("cmp");
        chk("cmp_flags", flags, 4'b0100);
        chk("cmp_wr", writereg_out, 1'b0);
        set_op(4'd11, 16'h8001, 16'h0, 4'd1, 2'b00, 16'h0);
        step("sra");
        chk("sra_res", result, 16'hC000);
        chk("sra_c", flags[1], 1'b1);
        set_op(4'd9, 16'h8001, 16'h0, 4'd4, 2'b00, 16'h0);
        step("slr");
        chk("slr_res", result, 16'h0018);
        chk("slr_c", flags[1], 1'b0);
        set_op(4'd8, 16'h5A5A, 16'h0, 4'd0, 2'b00, 16'h0);
        step("sll0");
        chk("sll0_res", result, 16'h5A5A);
        chk("sll0_c", flags[1], 1'b0);
        set_op(4'd0, 16'h0100, 16'h0020, 4'd0, 2'b00, 16'h0);
        step("add2");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(4'd1, 16'($urandom), 16'($urandom), 4'd0, 2'b00, 16'h0);
            step("stall");
            chk("stall_res", result, 16'h0120);
        end
        stall = 1'b0;
        step("unstall");
        set_op(4'd15, 16'h0, 16'h0, 4'd0, 2'b00, 16'h0);
        stall = 1'b1;
        step("hlt_stall");
        chk("hlt_stall_halted", halted, 1'b0);
        stall = 1'b0;
        set_op(4'd13, 16'h0, 16'hBEEF, 4'd0, 2'b00, 16'h0);
        step("out");
        chk("out_port", out_port, 16'hBEEF);
        chk("out_strobe", out_strobe, 1'b1);
        set_op(4'd0, 16'h0, 16'h0, 4'd0, 2'b01, 16'h0040);
        step("load");
        chk("load_res", result, 16'h0040);
        chk("load_strobe", out_strobe, 1'b0);
        set_op(4'd13, 16'h0, 16'h1111, 4'd0, 2'b00, 16'h0);
        step("out_a");
        set_op(4'd13, 16'h0, 16'h2222, 4'd0, 2'b00, 16'h0);
        step("out_b");
        chk("out_b_strobe", out_strobe, 1'b1);
        set_op(4'd7, 16'h1, 16'h2, 4'd0, 2'b00, 16'h0);
        step("nop");
        in_valid = 1'b0;
        step("bubble");
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 6));
            set_op(4'($urandom_range(0, 14)), 16'($urandom), 16'($urandom), 4'($urandom),
                   k == 5 ? 2'b01 : k == 6 ? 2'b10 : 2'b00, 16'($urandom));
            writereg = 1'($urandom);
            in_port = 16'($urandom);
            in_valid = $urandom_range(0, 9) < 8;
            stall = $urandom_range(0, 9) < 2;
            step("rand");
        end
        stall = 1'b0;
        set_op(4'd15, 16'h0, 16'h0, 4'd0, 2'b00, 16'h0);
        step("hlt");
        chk("hlt_valid", out_valid, 1'b0);
        chk("hlt_halted", halted, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_op(4'd0, 16'($urandom), 16'($urandom), 4'd0, 2'b00, 16'h0);
            step("halted_add");
        end
        stall = 1'b1;
        #3 reset = 1'b1;
        model_reset();
        #1;
        check_all("rst_halt");
        #2 reset = 1'b0;
        stall = 1'b0;
        set_op(4'd0, 16'h0002, 16'h0003, 4'd0, 2'b00, 16'h0);
        step("post_rst_add");
        chk("post_rst_res", result, 16'h0005);
        chk("post_rst_valid", out_valid, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
